msi_cpu_controller: RTL and testbench
=====================================

Name: msi_cpu_controller

Overview:
Processor-side half of the MSI snooping coherence protocol. The existing bus-side snoop FSM reacts to remote RM/Invalidate/WM operations; this block originates those operations. It holds a small direct-mapped tag/state store, classifies each local CPU read/write as hit or miss, and issues the required bus operations over a req/gnt handshake, including write-back of an Exclusive victim. It sits between the CPU stub (switches/keys on the board top) and the shared bus arbiter.

Parameters:
INDEX_W, 2, line index width; NUM_LINES = 2**INDEX_W
TAG_W, 4, tag width; cpu_addr width = TAG_W+INDEX_W

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
cpu_valid  input  1  CPU request strobe, sampled only while cpu_ready=1
cpu_write  input  1  1 = write, 0 = read
cpu_addr  input  TAG_W+INDEX_W  {tag, index}
cpu_ready  output  1  controller idle, accepts a request
cpu_done  output  1  one-cycle pulse, request complete
cpu_hit  output  1  valid with cpu_done; 1 = no bus traffic was needed
bus_req  output  1  bus request; held until granted
bus_op  output  2  00 RM, 01 Invalidate, 10 WM, 11 WriteBack
bus_addr  output  TAG_W+INDEX_W  block address of current bus op
bus_gnt  input  1  arbiter grant; op completes on the edge where req&gnt=1
line_state  output  2  final state of the accessed line, valid with cpu_done (00 Invalid, 01 Exclusive, 10 Shared)

Behaviour:
- Line state encoding matches the snoop FSM: Invalid 00, Exclusive 01, Shared 10; 11 never stored.
- Reset (async): all lines Invalid, tags 0, FSM IDLE, cpu_ready=1, cpu_done=0, cpu_hit=0, bus_req=0, bus_op=00, bus_addr=0, line_state=00.
- FSM states: IDLE, WB_REQ, MISS_REQ, DONE.
- IDLE: cpu_ready=1. On cpu_valid, latch write/addr, read line[index]. hit = state!=Invalid and tag matches.
- Transition table (current state, access -> bus ops, new state):
  Invalid, read -> RM -> Shared
  Invalid, write -> WM -> Exclusive
  Shared, read hit -> none -> Shared
  Shared, write hit -> Invalidate -> Exclusive
  Shared, read miss (tag mismatch) -> RM -> Shared (no write-back)
  Shared, write miss -> WM -> Exclusive (no write-back)
  Exclusive, read/write hit -> none -> Exclusive
  Exclusive, read miss -> WriteBack(old tag), then RM -> Shared
  Exclusive, write miss -> WriteBack(old tag), then WM -> Exclusive
- No-bus case: IDLE -> DONE; cpu_done high the following cycle (latency 1), cpu_hit=1.
- Invalidate on Shared write hit counts as cpu_hit=0 (bus traffic used).
- WB_REQ: bus_req=1, bus_op=11, bus_addr={old tag, index}; on bus_gnt -> MISS_REQ.
- MISS_REQ: bus_req=1, bus_op per table, bus_addr={new tag, index}; on bus_gnt, write new tag and state into the line and -> DONE.
- bus_req, bus_op and bus_addr are registered and stable while waiting. No timeout: the controller waits indefinitely for bus_gnt.
- bus_req drops in the cycle after the grant edge. Back-to-back WB -> miss op keeps bus_req high with bus_op changing; the arbiter sees a new op.
- DONE: cpu_done=1 for exactly one cycle, with line_state and cpu_hit valid. Returns to IDLE; cpu_ready=0 during DONE.
- A cpu_valid arriving while cpu_ready=0 is ignored, not queued.
- Lines are updated only on completion. A line never changes while its request is pending.
- Reset mid-transaction aborts: bus_req falls immediately, and the store clears.

Test Plan:
- Reset, read addr 0x05 (tag 1, idx 1): bus_req with op 00, addr 0x05; gnt after 3 cycles -> cpu_done, hit=0, line_state=10. Reread 0x05 -> done 1 cycle later, hit=1, no bus_req.
- Shared line 0x05, write 0x05: op 01 Invalidate, addr 0x05 -> line_state=01. Second write -> hit=1, state stays 01.
- Exclusive 0x05, read 0x09 (tag 2, idx 1): WriteBack op 11 addr 0x05, then RM op 00 addr 0x09 -> line_state=10.
- Shared 0x09, write 0x0D (tag 3, idx 1): single WM op 10 addr 0x0D with no write-back -> state 01.
- gnt held low 20 cycles: bus_req/op/addr stable; cpu_valid pulses ignored, cpu_ready=0.
- Assert reset while waiting for gnt: bus_req=0 asynchronously. A following read of the previously Exclusive address misses and issues RM with no write-back.

Source files
------------

// File: rtl/msi_cpu_controller_if.sv
// CPU request/response and shared-bus request/grant signals of the MSI processor-side controller.
interface msi_cpu_controller_if #(
   parameter int ADDR_W = 6
);
   logic              cpu_valid;
   logic              cpu_write;
   logic [ADDR_W-1:0] cpu_addr;
   logic              cpu_ready;
   logic              cpu_done;
   logic              cpu_hit;
   logic              bus_req;
   logic [1:0]        bus_op;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_gnt;
   logic [1:0]        line_state;

   // master: CPU stub plus arbiter; slave: the controller
   modport master (
      output cpu_valid, cpu_write, cpu_addr, bus_gnt,
      input  cpu_ready, cpu_done, cpu_hit, bus_req, bus_op, bus_addr, line_state
   );

   modport slave (
      input  cpu_valid, cpu_write, cpu_addr, bus_gnt,
      output cpu_ready, cpu_done, cpu_hit, bus_req, bus_op, bus_addr, line_state
   );
endinterface

// File: rtl/msi_cpu_controller.sv
// MSI processor-side controller: direct-mapped tag/state store, issues RM/Invalidate/WM/WriteBack.
// Hits complete one cycle after acceptance; misses wait indefinitely on bus_gnt with bus signals held.
module msi_cpu_controller #(
   parameter int INDEX_W = 2,
   parameter int TAG_W   = 4
) (
   input logic clock,
   input logic reset,
   msi_cpu_controller_if.slave io
);
   localparam int ADDR_W    = TAG_W + INDEX_W;
   localparam int NUM_LINES = 2 ** INDEX_W;

   localparam logic [1:0] ST_I = 2'b00;
   localparam logic [1:0] ST_E = 2'b01;
   localparam logic [1:0] ST_S = 2'b10;

   localparam logic [1:0] OP_RM  = 2'b00;
   localparam logic [1:0] OP_INV = 2'b01;
   localparam logic [1:0] OP_WM  = 2'b10;
   localparam logic [1:0] OP_WB  = 2'b11;

   typedef enum logic [1:0] {IDLE, WB_REQ, MISS_REQ, DONE} fsm_t;

   fsm_t              state_q, state_d;
   logic [TAG_W-1:0]  tag_q [NUM_LINES];
   logic [TAG_W-1:0]  tag_d [NUM_LINES];
   logic [1:0]        st_q  [NUM_LINES];
   logic [1:0]        st_d  [NUM_LINES];
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        new_st_q, new_st_d;
   logic              hit_q, hit_d;
   logic [1:0]        line_state_q, line_state_d;
   logic              bus_req_q, bus_req_d;
   logic [1:0]        bus_op_q, bus_op_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;

   logic [INDEX_W-1:0] cpu_idx;
   logic [TAG_W-1:0]   cpu_tag;
   logic [1:0]         cur_st;
   logic [TAG_W-1:0]   cur_tag;
   logic               cpu_hit_lookup;
   logic [INDEX_W-1:0] req_idx;

   assign cpu_idx        = io.cpu_addr[INDEX_W-1:0];
   assign cpu_tag        = io.cpu_addr[ADDR_W-1:INDEX_W];
   assign cur_st         = st_q[cpu_idx];
   assign cur_tag        = tag_q[cpu_idx];
   assign cpu_hit_lookup = (cur_st != ST_I) && (cur_tag == cpu_tag);
   assign req_idx        = addr_q[INDEX_W-1:0];

   always_comb begin
      state_d      = state_q;
      tag_d        = tag_q;
      st_d         = st_q;
      wr_d         = wr_q;
      addr_d       = addr_q;
      new_st_d     = new_st_q;
      hit_d        = hit_q;
      line_state_d = line_state_q;
      bus_req_d    = bus_req_q;
      bus_op_d     = bus_op_q;
      bus_addr_d   = bus_addr_q;
      unique case (state_q)
         IDLE: begin
            if (io.cpu_valid) begin
               wr_d     = io.cpu_write;
               addr_d   = io.cpu_addr;
               new_st_d = io.cpu_write ? ST_E : ST_S;
               if (cpu_hit_lookup && (!io.cpu_write || cur_st == ST_E)) begin
                  hit_d        = 1'b1;
                  line_state_d = cur_st;
                  state_d      = DONE;
               end else if (cpu_hit_lookup) begin
                  // Shared write hit: upgrade with Invalidate, counts as bus traffic
                  bus_req_d  = 1'b1;
                  bus_op_d   = OP_INV;
                  bus_addr_d = io.cpu_addr;
                  state_d    = MISS_REQ;
               end else if (cur_st == ST_E) begin
                  bus_req_d  = 1'b1;
                  bus_op_d   = OP_WB;
                  bus_addr_d = {cur_tag, cpu_idx};
                  state_d    = WB_REQ;
               end else begin
                  bus_req_d  = 1'b1;
                  bus_op_d   = io.cpu_write ? OP_WM : OP_RM;
                  bus_addr_d = io.cpu_addr;
                  state_d    = MISS_REQ;
               end
            end
         end
         WB_REQ: begin
            if (io.bus_gnt) begin
               bus_op_d   = wr_q ? OP_WM : OP_RM;
               bus_addr_d = addr_q;
               state_d    = MISS_REQ;
            end
         end
         MISS_REQ: begin
            if (io.bus_gnt) begin
               tag_d[req_idx] = addr_q[ADDR_W-1:INDEX_W];
               st_d[req_idx]  = new_st_q;
               bus_req_d      = 1'b0;
               hit_d          = 1'b0;
               line_state_d   = new_st_q;
               state_d        = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         for (int i = 0; i < NUM_LINES; i++) begin
            tag_q[i] <= '0;
            st_q[i]  <= ST_I;
         end
         wr_q         <= 1'b0;
         addr_q       <= '0;
         new_st_q     <= ST_I;
         hit_q        <= 1'b0;
         line_state_q <= ST_I;
         bus_req_q    <= 1'b0;
         bus_op_q     <= OP_RM;
         bus_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         st_q         <= st_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         new_st_q     <= new_st_d;
         hit_q        <= hit_d;
         line_state_q <= line_state_d;
         bus_req_q    <= bus_req_d;
         bus_op_q     <= bus_op_d;
         bus_addr_q   <= bus_addr_d;
      end
   end

   assign io.cpu_ready  = (state_q == IDLE);
   assign io.cpu_done   = (state_q == DONE);
   assign io.cpu_hit    = hit_q;
   assign io.line_state = line_state_q;
   assign io.bus_req    = bus_req_q;
   assign io.bus_op     = bus_op_q;
   assign io.bus_addr   = bus_addr_q;
endmodule

// File: tb/tb_msi_cpu_controller.sv
// Bench for msi_cpu_controller: vector table of accesses, scoreboard of bus ops and completions.
module tb_msi_cpu_controller;
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   msi_cpu_controller_if #(.ADDR_W(6)) bif ();
   msi_cpu_controller #(.INDEX_W(2), .TAG_W(4)) dut (.clock(clock), .reset(reset), .io(bif));

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {logic [1:0] op; logic [5:0] addr;} op_t;
   typedef struct {logic hit; logic [1:0] st;} cmp_t;
   typedef struct {
      bit wr; logic [5:0] addr; int nops;
      logic [1:0] op0; logic [5:0] a0; logic [1:0] op1; logic [5:0] a1;
      logic hit; logic [1:0] st;
   } vec_t;

   op_t  op_q[$];
   cmp_t cmp_q[$];
   vec_t vecs[12];

   bit arb_en    = 1'b1;
   int gnt_delay = 3;
   int wait_cnt  = 0;

   task automatic check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Arbiter model: grant gnt_delay cycles after request, single-cycle grant pulse
   initial begin
      bif.bus_gnt = 1'b0;
      forever begin
         @(negedge clock);
         if (bif.bus_gnt) begin
            bif.bus_gnt = 1'b0;
            wait_cnt    = 0;
         end else if (!bif.bus_req || reset) begin
            wait_cnt = 0;
         end else if (arb_en) begin
            if (wait_cnt >= gnt_delay) bif.bus_gnt = 1'b1;
            else wait_cnt++;
         end
      end
   end

   initial begin : monitor
      op_t  e;
      cmp_t c;
      forever begin
         @(negedge clock);
         #1;
         if (!reset) begin
            if (bif.bus_req && bif.bus_gnt) begin
               if (op_q.size() == 0) fail_now("unexpected_bus_op");
               else begin
                  e = op_q.pop_front();
                  check("bus_op", int'(bif.bus_op), int'(e.op));
                  check("bus_addr", int'(bif.bus_addr), int'(e.addr));
               end
            end
            if (bif.cpu_done) begin
               if (cmp_q.size() == 0) fail_now("unexpected_cpu_done");
               else begin
                  c = cmp_q.pop_front();
                  check("cpu_hit", int'(bif.cpu_hit), int'(c.hit));
                  check("line_state", int'(bif.line_state), int'(c.st));
               end
            end
         end
      end
   end

   task automatic issue(bit wr, logic [5:0] a);
      int t = 0;
      while (!bif.cpu_ready && t < 100) begin
         @(negedge clock);
         t++;
      end
      if (!bif.cpu_ready) fail_now("cpu_ready_timeout");
      bif.cpu_valid = 1'b1;
      bif.cpu_write = wr;
      bif.cpu_addr  = a;
      @(negedge clock);
      bif.cpu_valid = 1'b0;
   endtask

   task automatic wait_done();
      int t = 0;
      while (cmp_q.size() != 0 && t < 300) begin
         @(negedge clock);
         t++;
      end
      if (cmp_q.size() != 0) fail_now("cpu_done_timeout");
   endtask

   task automatic run_vec(vec_t v);
      op_t  o;
      cmp_t c;
      if (v.nops > 1) begin o.op = v.op1; o.addr = v.a1; end
      if (v.nops > 0) begin
         o.op = v.op0; o.addr = v.a0; op_q.push_back(o);
      end
      if (v.nops > 1) begin
         o.op = v.op1; o.addr = v.a1; op_q.push_back(o);
      end
      c.hit = v.hit; c.st = v.st;
      cmp_q.push_back(c);
      issue(v.wr, v.addr);
      if (v.nops == 0) begin
         check("hit_latency_done", int'(bif.cpu_done), 1);
         check("hit_no_req", int'(bif.bus_req), 0);
      end
      wait_done();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      op_t  o;
      cmp_t c;
      //          wr    addr  n  op0    a0     op1    a1     hit   st
      vecs[0]  = '{1'b0, 6'h05, 1, 2'b00, 6'h05, 2'b00, 6'h00, 1'b0, 2'b10};
      vecs[1]  = '{1'b0, 6'h05, 0, 2'b00, 6'h00, 2'b00, 6'h00, 1'b1, 2'b10};
      vecs[2]  = '{1'b1, 6'h05, 1, 2'b01, 6'h05, 2'b00, 6'h00, 1'b0, 2'b01};
      vecs[3]  = '{1'b1, 6'h05, 0, 2'b00, 6'h00, 2'b00, 6'h00, 1'b1, 2'b01};
      vecs[4]  = '{1'b0, 6'h09, 2, 2'b11, 6'h05, 2'b00, 6'h09, 1'b0, 2'b10};
      vecs[5]  = '{1'b1, 6'h0D, 1, 2'b10, 6'h0D, 2'b00, 6'h00, 1'b0, 2'b01};
      vecs[6]  = '{1'b0, 6'h0D, 0, 2'b00, 6'h00, 2'b00, 6'h00, 1'b1, 2'b01};
      vecs[7]  = '{1'b0, 6'h02, 1, 2'b00, 6'h02, 2'b00, 6'h00, 1'b0, 2'b10};
      vecs[8]  = '{1'b1, 6'h3F, 1, 2'b10, 6'h3F, 2'b00, 6'h00, 1'b0, 2'b01};
      vecs[9]  = '{1'b1, 6'h0F, 2, 2'b11, 6'h3F, 2'b10, 6'h0F, 1'b0, 2'b01};
      vecs[10] = '{1'b0, 6'h00, 1, 2'b00, 6'h00, 2'b00, 6'h00, 1'b0, 2'b10};
      vecs[11] = '{1'b1, 6'h30, 1, 2'b10, 6'h30, 2'b00, 6'h00, 1'b0, 2'b01};

      reset         = 1'b1;
      bif.cpu_valid = 1'b0;
      bif.cpu_write = 1'b0;
      bif.cpu_addr  = '0;
      repeat (2) @(negedge clock);
      check("rst_cpu_ready", int'(bif.cpu_ready), 1);
      check("rst_cpu_done", int'(bif.cpu_done), 0);
      check("rst_cpu_hit", int'(bif.cpu_hit), 0);
      check("rst_bus_req", int'(bif.bus_req), 0);
      check("rst_bus_op", int'(bif.bus_op), 0);
      check("rst_bus_addr", int'(bif.bus_addr), 0);
      check("rst_line_state", int'(bif.line_state), 0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 12; i++) run_vec(vecs[i]);

      // Long grant stall: idx1 holds tag3 Exclusive, read 0x15 needs write-back first
      arb_en = 1'b0;
      o.op = 2'b11; o.addr = 6'h0D; op_q.push_back(o);
      o.op = 2'b00; o.addr = 6'h15; op_q.push_back(o);
      c.hit = 1'b0; c.st = 2'b10; cmp_q.push_back(c);
      issue(1'b0, 6'h15);
      for (int i = 0; i < 20; i++) begin
         check("stall_bus_req", int'(bif.bus_req), 1);
         check("stall_bus_op", int'(bif.bus_op), 3);
         check("stall_bus_addr", int'(bif.bus_addr), 6'h0D);
         check("stall_cpu_ready", int'(bif.cpu_ready), 0);
         bif.cpu_valid = (i % 5 == 2);
         bif.cpu_write = 1'b1;
         bif.cpu_addr  = 6'(i);
         @(negedge clock);
      end
      bif.cpu_valid = 1'b0;
      arb_en = 1'b1;
      wait_done();

      // Make 0x15 Exclusive, then abort its write-back with reset
      v = '{1'b1, 6'h15, 1, 2'b01, 6'h15, 2'b00, 6'h00, 1'b0, 2'b01};
      run_vec(v);
      arb_en = 1'b0;
      issue(1'b0, 6'h25);
      repeat (4) @(negedge clock);
      check("pre_rst_bus_req", int'(bif.bus_req), 1);
      check("pre_rst_bus_addr", int'(bif.bus_addr), 6'h15);
      #2 reset = 1'b1;
      #1;
      check("async_rst_bus_req", int'(bif.bus_req), 0);
      check("async_rst_cpu_ready", int'(bif.cpu_ready), 1);
      op_q.delete();
      cmp_q.delete();
      @(negedge clock);
      reset  = 1'b0;
      arb_en = 1'b1;
      @(negedge clock);
      v = '{1'b0, 6'h15, 1, 2'b00, 6'h15, 2'b00, 6'h00, 1'b0, 2'b10};
      run_vec(v);
      v = '{1'b1, 6'h0F, 1, 2'b10, 6'h0F, 2'b00, 6'h00, 1'b0, 2'b01};
      run_vec(v);

      repeat (3) @(negedge clock);
      check("op_q_drained", op_q.size(), 0);
      check("cmp_q_drained", cmp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
